// File: rtl/bottle_line_ctrl_pkg.sv
// rtl/bottle_line_ctrl_pkg.sv - state encodings, default constants and actuator decode for the bottle line
package bottle_line_ctrl_pkg;

    localparam int DEF_CAP_MAX      = 15;
    localparam int DEF_CAP_W        = 4;
    localparam int DEF_FILL_TIMEOUT = 50;
    localparam int DEF_CAP_CYCLES   = 3;
    localparam int DEF_TMR_W        = 6;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CONVEY = 3'd1,
        ST_FILL   = 3'd2,
        ST_CAP    = 3'd3,
        ST_EXIT   = 3'd4,
        ST_FAULT  = 3'd5
    } state_t;

    typedef struct packed {
        logic motor;
        logic valve;
        logic capper;
        logic fault;
    } act_t;

    // Actuator outputs depend on the state alone, so they are decoded from it.
    function automatic act_t state_act(input state_t s);
        act_t a;
        a = '0;
        case (s)
            ST_CONVEY: a.motor  = 1'b1;
            ST_FILL:   a.valve  = 1'b1;
            ST_CAP:    a.capper = 1'b1;
            ST_EXIT:   a.motor  = 1'b1;
            ST_FAULT:  a.fault  = 1'b1;
            default:   a = '0;
        endcase
        return a;
    endfunction

endpackage

// File: rtl/bottle_line_ctrl_if.sv
// rtl/bottle_line_ctrl_if.sv - station sensor/command inputs and actuator/status outputs
interface bottle_line_ctrl_if
    import bottle_line_ctrl_pkg::*;
#(
    parameter int CAP_W = DEF_CAP_W
);
    logic             start;
    logic             stop;
    logic             pos_sensor;
    logic             full_sensor;
    logic             cap_refill;
    logic             clear_fault;
    logic             motor_on;
    logic             valve_on;
    logic             capper_on;
    logic             bottle_done;
    logic [CAP_W-1:0] caps_left;
    logic             no_caps;
    logic             fault;

    modport master (
        output start, stop, pos_sensor, full_sensor, cap_refill, clear_fault,
        input  motor_on, valve_on, capper_on, bottle_done, caps_left, no_caps, fault
    );

    modport slave (
        input  start, stop, pos_sensor, full_sensor, cap_refill, clear_fault,
        output motor_on, valve_on, capper_on, bottle_done, caps_left, no_caps, fault
    );
endinterface

// File: rtl/bottle_line_ctrl_cycle_timer.sv
// rtl/bottle_line_ctrl_cycle_timer.sv - up-counter with sync clear and enable, shared by FILL and CAP
module bottle_line_ctrl_cycle_timer
    import bottle_line_ctrl_pkg::*;
#(
    parameter int TMR_W = DEF_TMR_W
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_clr,
    input  logic             i_en,
    output logic [TMR_W-1:0] o_count
);
    logic [TMR_W-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_reset || i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + TMR_W'(1);
        end
    end

    assign o_count = r_count;
endmodule

// File: rtl/bottle_line_ctrl.sv
// rtl/bottle_line_ctrl.sv - filling/capping station sequencer with cap stock tracking
module bottle_line_ctrl
    import bottle_line_ctrl_pkg::*;
#(
    parameter int CAP_MAX      = DEF_CAP_MAX,
    parameter int CAP_W        = DEF_CAP_W,
    parameter int FILL_TIMEOUT = DEF_FILL_TIMEOUT,
    parameter int CAP_CYCLES   = DEF_CAP_CYCLES,
    parameter int TMR_W        = DEF_TMR_W
) (
    input  logic          i_clk,
    input  logic          i_reset,
    bottle_line_ctrl_if.slave bus
);
    state_t           r_state;
    act_t             r_act;
    logic             r_done;
    logic             r_run;
    logic [CAP_W-1:0] r_caps;
    logic             r_no_caps;

    logic [TMR_W-1:0] w_tmr;
    logic             w_tmr_en;
    logic             w_tmr_clr;
    logic             w_cap_last;
    logic             w_fill_timeout;
    logic             w_caps_empty;
    logic             w_run_set;
    logic             w_run_clr;
    logic             w_run_next;

    // The timer runs only while waiting for full level or while capping; any other cycle zeroes it.
    assign w_tmr_en       = ((r_state == ST_FILL) && !bus.full_sensor) || (r_state == ST_CAP);
    assign w_tmr_clr      = !w_tmr_en;
    assign w_cap_last     = (r_state == ST_CAP) && (w_tmr == TMR_W'(CAP_CYCLES - 1));
    assign w_fill_timeout = (w_tmr == TMR_W'(FILL_TIMEOUT - 1));
    assign w_caps_empty   = (r_caps == '0);

    assign w_run_clr  = bus.stop || (r_state == ST_FAULT) || ((r_state == ST_EXIT) && w_caps_empty);
    assign w_run_set  = bus.start && !w_caps_empty && (r_state != ST_FAULT);
    assign w_run_next = w_run_clr ? 1'b0 : (w_run_set ? 1'b1 : r_run);

    bottle_line_ctrl_cycle_timer #(
        .TMR_W (TMR_W)
    ) u_timer (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_clr   (w_tmr_clr),
        .i_en    (w_tmr_en),
        .o_count (w_tmr)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_run <= 1'b0;
        end else begin
            r_run <= w_run_next;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_caps    <= CAP_W'(CAP_MAX);
            r_no_caps <= (CAP_MAX == 0);
        end else if (bus.cap_refill) begin
            r_caps    <= CAP_W'(CAP_MAX);
            r_no_caps <= (CAP_MAX == 0);
        end else if (w_cap_last && !w_caps_empty) begin
            r_caps    <= r_caps - CAP_W'(1);
            r_no_caps <= (r_caps == CAP_W'(1));
        end
    end

    // Actuators are registered from the state being entered so they always match r_state.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
            r_act   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_act  <= state_act(r_state);
            case (r_state)
                ST_IDLE: begin
                    if (r_run) begin
                        r_state <= ST_CONVEY;
                        r_act   <= state_act(ST_CONVEY);
                    end
                end
                ST_CONVEY: begin
                    if (bus.pos_sensor) begin
                        r_state <= ST_FILL;
                        r_act   <= state_act(ST_FILL);
                    end
                end
                ST_FILL: begin
                    if (bus.full_sensor) begin
                        r_state <= ST_CAP;
                        r_act   <= state_act(ST_CAP);
                    end else if (w_fill_timeout) begin
                        r_state <= ST_FAULT;
                        r_act   <= state_act(ST_FAULT);
                    end
                end
                ST_CAP: begin
                    if (w_cap_last) begin
                        r_state <= ST_EXIT;
                        r_act   <= state_act(ST_EXIT);
                    end
                end
                ST_EXIT: begin
                    if (!bus.pos_sensor) begin
                        r_done <= 1'b1;
                        if (w_run_next && !w_caps_empty) begin
                            r_state <= ST_CONVEY;
                            r_act   <= state_act(ST_CONVEY);
                        end else begin
                            r_state <= ST_IDLE;
                            r_act   <= state_act(ST_IDLE);
                        end
                    end
                end
                ST_FAULT: begin
                    if (bus.clear_fault) begin
                        r_state <= ST_IDLE;
                        r_act   <= state_act(ST_IDLE);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_act   <= state_act(ST_IDLE);
                end
            endcase
        end
    end

    assign bus.motor_on    = r_act.motor;
    assign bus.valve_on    = r_act.valve;
    assign bus.capper_on   = r_act.capper;
    assign bus.fault       = r_act.fault;
    assign bus.bottle_done = r_done;
    assign bus.caps_left   = r_caps;
    assign bus.no_caps     = r_no_caps;
endmodule

// File: tb/tb_bottle_line_ctrl.sv
// tb/tb_bottle_line_ctrl.sv - directed self-checking bench for bottle_line_ctrl
module tb_bottle_line_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int dz_cnt = 0;
    int dz_wraps = 0;

    bottle_line_ctrl_if #(.CAP_W(4)) bl ();

    bottle_line_ctrl dut (
        .i_clk   (clk),
        .i_reset (reset),
        .bus     (bl.slave)
    );

    always #5 clk = ~clk;

    // Dozen counter fed by bottle_done, as the downstream duzias block would see it.
    always @(negedge clk) begin
        if (bl.bottle_done === 1'b1) begin
            done_cnt++;
            if (dz_cnt == 11) begin
                dz_cnt = 0;
                dz_wraps++;
            end else begin
                dz_cnt++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic sig(input int sel);
        case (sel)
            0: return bl.motor_on;
            1: return bl.valve_on;
            2: return bl.capper_on;
            default: return bl.fault;
        endcase
    endfunction

    function automatic logic [3:0] acts();
        return {bl.motor_on, bl.valve_on, bl.capper_on, bl.fault};
    endfunction

    task automatic wait_for(input int sel, input int limit, input string nm);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < limit; i++) begin
            if (sig(sel) === 1'b1) begin
                hit = 1'b1;
                break;
            end
            tick();
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL %s wait timed out: actual=0 required=1", nm);
        end
    endtask

    task automatic run_bottle(input bit stop_in_fill, input int exp_caps);
        int n;
        wait_for(0, 20, "convey");
        bl.pos_sensor = 1'b1;
        tick();
        wait_for(1, 5, "fill");
        if (stop_in_fill) bl.stop = 1'b1;
        tick();
        bl.stop = 1'b0;
        bl.full_sensor = 1'b1;
        tick();
        wait_for(2, 5, "cap");
        n = 0;
        while (bl.capper_on === 1'b1 && n < 10) begin
            n++;
            tick();
        end
        checks++;
        if (n !== 3) begin errors++; $display("FAIL capper_cycles actual=%0d required=3", n); end
        checks++;
        if (acts() !== 4'b1000) begin errors++; $display("FAIL exit_acts actual=%b required=1000", acts()); end
        bl.pos_sensor = 1'b0;
        bl.full_sensor = 1'b0;
        tick();
        checks++;
        if (bl.bottle_done !== 1'b1) begin errors++; $display("FAIL done_pulse actual=%b required=1", bl.bottle_done); end
        checks++;
        if (bl.caps_left !== 4'(exp_caps)) begin errors++; $display("FAIL caps_left actual=%0d required=%0d", bl.caps_left, exp_caps); end
        tick();
        checks++;
        if (bl.bottle_done !== 1'b0) begin errors++; $display("FAIL done_width actual=%b required=0", bl.bottle_done); end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        checks++;
        if ({acts(), bl.bottle_done, bl.no_caps} !== 6'b0) begin
            errors++; $display("FAIL reset_outputs actual=%b required=000000", {acts(), bl.bottle_done, bl.no_caps});
        end
        checks++;
        if (bl.caps_left !== 4'd15) begin errors++; $display("FAIL reset_caps actual=%0d required=15", bl.caps_left); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_single_bottle();
        bl.start = 1'b1;
        tick();
        bl.start = 1'b0;
        run_bottle(1'b0, 14);
        checks++;
        if (acts() !== 4'b1000) begin errors++; $display("FAIL back_in_convey actual=%b required=1000", acts()); end
    endtask

    task automatic test_dozen();
        dz_cnt = 0;
        dz_wraps = 0;
        for (int i = 0; i < 12; i++) run_bottle(1'b0, 13 - i);
        checks++;
        if (dz_wraps !== 1 || dz_cnt !== 0) begin
            errors++; $display("FAIL dozen_wrap actual=%0d/%0d required=1/0", dz_wraps, dz_cnt);
        end
    endtask

    task automatic test_fill_timeout();
        int n;
        bl.pos_sensor = 1'b1;
        tick();
        wait_for(1, 5, "fill_to");
        n = 0;
        while (bl.valve_on === 1'b1 && n < 60) begin
            n++;
            tick();
        end
        checks++;
        if (n !== 50) begin errors++; $display("FAIL fill_timeout_cycles actual=%0d required=50", n); end
        checks++;
        if (acts() !== 4'b0001) begin errors++; $display("FAIL fault_acts actual=%b required=0001", acts()); end
        bl.start = 1'b1;
        tick();
        tick();
        bl.start = 1'b0;
        tick();
        checks++;
        if (acts() !== 4'b0001) begin errors++; $display("FAIL fault_start_ignored actual=%b required=0001", acts()); end
        bl.pos_sensor = 1'b0;
        bl.clear_fault = 1'b1;
        tick();
        bl.clear_fault = 1'b0;
        tick();
        checks++;
        if (acts() !== 4'b0000) begin errors++; $display("FAIL clear_to_idle actual=%b required=0000", acts()); end
        bl.start = 1'b1;
        tick();
        bl.start = 1'b0;
        run_bottle(1'b0, 1);
    endtask

    task automatic test_caps_empty();
        run_bottle(1'b0, 0);
        checks++;
        if (bl.no_caps !== 1'b1) begin errors++; $display("FAIL no_caps actual=%b required=1", bl.no_caps); end
        checks++;
        if (acts() !== 4'b0000) begin errors++; $display("FAIL empty_idle actual=%b required=0000", acts()); end
        bl.start = 1'b1;
        tick();
        bl.start = 1'b0;
        tick();
        tick();
        tick();
        checks++;
        if (bl.motor_on !== 1'b0) begin errors++; $display("FAIL start_when_empty actual=%b required=0", bl.motor_on); end
        bl.cap_refill = 1'b1;
        tick();
        bl.cap_refill = 1'b0;
        checks++;
        if (bl.caps_left !== 4'd15 || bl.no_caps !== 1'b0) begin
            errors++; $display("FAIL refill actual=%0d/%b required=15/0", bl.caps_left, bl.no_caps);
        end
    endtask

    task automatic test_stop_mid_bottle();
        int d0;
        d0 = done_cnt;
        bl.start = 1'b1;
        tick();
        bl.start = 1'b0;
        run_bottle(1'b1, 14);
        tick();
        tick();
        checks++;
        if (acts() !== 4'b0000) begin errors++; $display("FAIL stop_idle actual=%b required=0000", acts()); end
        checks++;
        if (done_cnt - d0 !== 1) begin errors++; $display("FAIL stop_done_count actual=%0d required=1", done_cnt - d0); end
    endtask

    task automatic test_refill_and_reset_in_cap();
        int d0;
        bl.start = 1'b1;
        tick();
        bl.start = 1'b0;
        wait_for(0, 20, "convey6");
        bl.pos_sensor = 1'b1;
        tick();
        wait_for(1, 5, "fill6");
        bl.full_sensor = 1'b1;
        tick();
        wait_for(2, 5, "cap6");
        tick();
        tick();
        checks++;
        if (bl.capper_on !== 1'b1) begin errors++; $display("FAIL cap_third_cycle actual=%b required=1", bl.capper_on); end
        bl.cap_refill = 1'b1;
        tick();
        bl.cap_refill = 1'b0;
        checks++;
        if (bl.caps_left !== 4'd15) begin errors++; $display("FAIL refill_wins actual=%0d required=15", bl.caps_left); end
        bl.pos_sensor = 1'b0;
        bl.full_sensor = 1'b0;
        tick();
        tick();
        wait_for(0, 20, "convey6b");
        bl.pos_sensor = 1'b1;
        tick();
        wait_for(1, 5, "fill6b");
        bl.full_sensor = 1'b1;
        tick();
        wait_for(2, 5, "cap6b");
        d0 = done_cnt;
        reset = 1'b1;
        tick();
        checks++;
        if ({acts(), bl.bottle_done, bl.no_caps} !== 6'b0 || bl.caps_left !== 4'd15) begin
            errors++; $display("FAIL reset_in_cap actual=%b/%0d required=000000/15", {acts(), bl.bottle_done, bl.no_caps}, bl.caps_left);
        end
        tick();
        reset = 1'b0;
        bl.pos_sensor = 1'b0;
        bl.full_sensor = 1'b0;
        tick();
        tick();
        checks++;
        if (done_cnt !== d0 || acts() !== 4'b0000) begin
            errors++; $display("FAIL reset_no_done actual=%0d/%b required=%0d/0000", done_cnt, acts(), d0);
        end
    endtask

    initial begin
        bl.start = 1'b0;
        bl.stop = 1'b0;
        bl.pos_sensor = 1'b0;
        bl.full_sensor = 1'b0;
        bl.cap_refill = 1'b0;
        bl.clear_fault = 1'b0;
        test_reset();
        test_single_bottle();
        test_dozen();
        test_fill_timeout();
        test_caps_empty();
        test_stop_mid_bottle();
        test_refill_and_reset_in_cap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
